// File: rtl/modp_inv_arb.sv
// modp_inv_arb
// Round-robin arbiter and sequencer sharing one modular-inversion engine
// (inverse mod p = 2^255 - 19) between NREQ requesters.
//
// The engine has no completion flag, so after launching it with a one-cycle
// eng_en pulse the arbiter counts a fixed INV_LATENCY. It then captures
// eng_result and returns it with a one-cycle done pulse to the requester
// that was granted. A zero operand has no inverse: it is answered directly
// with result = 0, and the engine is not started.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (also resets the engine)
//   req        in   [NREQ]    level request per requester
//   x_in       in   [NREQ*N]  operands, requester i at [i*N +: N]
//   gnt        out  [NREQ]    one-hot pulse: operand accepted
//   done       out  [NREQ]    one-hot pulse: result valid for that requester
//   result     out  [N]       inverse, held until the next capture
//   busy       out            high while an engine operation is in flight
//   eng_en     out            engine start pulse
//   eng_x      out  [N]       engine operand (registered)
//   eng_result in   [N]       engine output
module modp_inv_arb #(
   parameter int N           = 255,
   parameter int NREQ        = 2,
   parameter int INV_LATENCY = 65536
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] x_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [N-1:0]      result,
   output logic              busy,
   output logic              eng_en,
   output logic [N-1:0]      eng_x,
   input  logic [N-1:0]      eng_result
);

   localparam int IW  = $clog2(NREQ);
   localparam int IW1 = IW + 1;
   localparam int CW  = $clog2(INV_LATENCY + 1);

   typedef enum logic [0:0] {IDLE, WAIT} state_t;

   state_t          state;
   logic [IW-1:0]   last;     // most recently granted requester
   logic [IW-1:0]   w;        // requester owning the in-flight operation
   logic [CW-1:0]   cnt;      // cycles since the eng_en cycle

   // Round-robin pick: first set request after 'last', wrapping modulo NREQ.
   logic            any_req;
   logic [IW-1:0]   win;
   logic [IW1-1:0]  cand;
   logic [N-1:0]    win_x;
   logic [NREQ-1:0] win_onehot;
   logic [NREQ-1:0] w_onehot;

   always_comb begin
      any_req = 1'b0;
      win     = '0;
      cand    = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = {1'b0, last} + IW1'(off);
         if (cand >= IW1'(NREQ))
            cand = cand - IW1'(NREQ);
         if (!any_req && req[cand[IW-1:0]]) begin
            any_req = 1'b1;
            win     = cand[IW-1:0];
         end
      end
   end

   assign win_x      = x_in[int'(win)*N +: N];
   assign win_onehot = NREQ'(1) << win;
   assign w_onehot   = NREQ'(1) << w;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         last   <= IW'(NREQ - 1);
         w      <= '0;
         cnt    <= '0;
         gnt    <= '0;
         done   <= '0;
         result <= '0;
         busy   <= 1'b0;
         eng_en <= 1'b0;
         eng_x  <= '0;
      end else begin
         // Pulses default low; each is raised for exactly one cycle below.
         gnt    <= '0;
         done   <= '0;
         eng_en <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt  <= win_onehot;
                  last <= win;
                  w    <= win;
                  if (win_x == '0) begin
                     // Zero has no inverse: answer at once, engine untouched.
                     result <= '0;
                     done   <= win_onehot;
                  end else begin
                     eng_x  <= win_x;
                     eng_en <= 1'b1;
                     cnt    <= '0;
                     busy   <= 1'b1;
                     state  <= WAIT;
                  end
               end
            end
            WAIT: begin
               // cnt is 0 in the eng_en cycle, so the engine output is valid
               // in the cycle where cnt reaches INV_LATENCY.
               if (cnt == CW'(INV_LATENCY)) begin
                  result <= eng_result;
                  done   <= w_onehot;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modp_inv_arb.sv
// tb_modp_inv_arb
// Scoreboard bench for modp_inv_arb with INV_LATENCY = 16. A behavioural
// engine registers x^(p-2) mod p sixteen cycles after eng_en and shows junk
// before that. Stimulus pushes expected grants and completions into queues.
// A negedge monitor pops and compares them whenever gnt or done appears.
module tb_modp_inv_arb;

   localparam int N    = 255;
   localparam int NREQ = 2;
   localparam int L    = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*N-1:0] x_in = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [N-1:0]      result;
   logic              busy;
   logic              eng_en;
   logic [N-1:0]      eng_x;
   logic [N-1:0]      eng_result;

   modp_inv_arb #(.N(N), .NREQ(NREQ), .INV_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .x_in(x_in),
      .gnt(gnt), .done(done), .result(result), .busy(busy),
      .eng_en(eng_en), .eng_x(eng_x), .eng_result(eng_result)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event occurred, none expected", name);
   endtask

   // ---------------- behavioural engine ----------------
   function automatic logic [N-1:0] mod_inv(input logic [N-1:0] x);
      logic [255:0] pp;
      logic [255:0] e;
      logic [511:0] r, b, pm;
      pp = (256'd1 << 255) - 256'd19;
      e  = pp - 256'd2;
      pm = 512'(pp);
      r  = 512'd1;
      b  = 512'(x) % pm;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = (r * b) % pm;
         b = (b * b) % pm;
      end
      return r[N-1:0];
   endfunction

   logic [N-1:0] junk;
   logic [N-1:0] pend;
   int           cd;

   initial begin
      junk = '1;
      junk = junk ^ (N'(1) << 100);
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         cd         <= 0;
         eng_result <= junk;
      end else if (eng_en) begin
         pend       <= mod_inv(eng_x);
         cd         <= L - 1;
         eng_result <= junk;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) eng_result <= pend;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int           idx;
      bit           launch;
      logic [N-1:0] opnd;
      int           gap;     // required cycles since previous done, -1 = unchecked
   } gexp_t;

   typedef struct {
      int           idx;
      logic [N-1:0] val;
      int           lat;     // required cycles from gnt to done
   } dexp_t;

   gexp_t gq[$];
   dexp_t dq[$];

   task automatic exp_gnt(input int idx, input bit launch, input logic [N-1:0] opnd, input int gap);
      gexp_t e;
      e.idx = idx; e.launch = launch; e.opnd = opnd; e.gap = gap;
      gq.push_back(e);
   endtask

   task automatic exp_done(input int idx, input logic [N-1:0] val, input int lat);
      dexp_t e;
      e.idx = idx; e.val = val; e.lat = lat;
      dq.push_back(e);
   endtask

   int cyc = 0;
   int gnt_cyc = 0;
   int done_cyc = -1000;

   always @(negedge clk) begin
      gexp_t g;
      dexp_t d;
      cyc++;
      if (gnt != '0) begin
         if (gq.size() == 0) begin
            flag("unexpected_gnt");
         end else begin
            g = gq.pop_front();
            chk("gnt_vector", 256'(gnt), 256'(NREQ'(1) << g.idx));
            chk("gnt_eng_en", 256'(eng_en), 256'(g.launch));
            chk("gnt_busy", 256'(busy), 256'(g.launch));
            if (g.launch) chk("eng_x", 256'(eng_x), 256'(g.opnd));
            if (g.gap >= 0) chk("gnt_gap", 256'(cyc - done_cyc), 256'(g.gap));
            $display("gnt  req%0d cycle %0d eng_en=%0b", g.idx, cyc, eng_en);
         end
         gnt_cyc = cyc;
      end else if (eng_en) begin
         flag("stray_eng_en");
      end
      if (done != '0) begin
         if (dq.size() == 0) begin
            flag("unexpected_done");
         end else begin
            d = dq.pop_front();
            chk("done_vector", 256'(done), 256'(NREQ'(1) << d.idx));
            chk("done_result", 256'(result), 256'(d.val));
            chk("done_latency", 256'(cyc - gnt_cyc), 256'(d.lat));
            chk("done_busy", 256'(busy), 256'd0);
            $display("done req%0d cycle %0d result=%h", d.idx, cyc, result);
         end
         done_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic run(input int ng, input int nd, input bit drop);
      int g = 0;
      int d = 0;
      int t = 0;
      while ((g < ng || d < nd) && t < 400) begin
         @(negedge clk);
         t++;
         if (gnt != '0) begin
            g++;
            if (drop) req = req & ~gnt;
         end
         if (done != '0) d++;
      end
      if (t >= 400) flag("timeout");
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_gnt"}, 256'(gnt), 256'd0);
      chk({tag, "_done"}, 256'(done), 256'd0);
      chk({tag, "_result"}, 256'(result), 256'd0);
      chk({tag, "_eng_en"}, 256'(eng_en), 256'd0);
      chk({tag, "_eng_x"}, 256'(eng_x), 256'd0);
      chk({tag, "_busy"}, 256'(busy), 256'd0);
   endtask

   task automatic set_x(input logic [N-1:0] x0, input logic [N-1:0] x1);
      x_in = {x1, x0};
   endtask

   logic [259:0] p_w, tmp;
   logic [N-1:0] inv1, inv2, inv3, inv4, inv5;

   initial begin
      // Hand-derived inverses mod p = 2^255 - 19.
      p_w  = (260'd1 << 255) - 260'd19;
      inv1 = N'(1);
      tmp  = (p_w + 260'd1) / 260'd2;             inv2 = tmp[N-1:0];  // 2^254 - 9
      tmp  = (260'd2 * p_w + 260'd1) / 260'd3;    inv3 = tmp[N-1:0];
      tmp  = (260'd3 * p_w + 260'd1) / 260'd4;    inv4 = tmp[N-1:0];
      tmp  = ((260'd1 << 255) - 260'd18) / 260'd5; inv5 = tmp[N-1:0];

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single request: x0 = 5
      set_x(N'(5), N'(0));
      exp_gnt(0, 1'b1, N'(5), -1);
      exp_done(0, inv5, L + 1);
      req = 2'b01;
      run(1, 1, 1'b1);
      repeat (3) @(negedge clk);

      // Simultaneous requests straight after reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      set_x(N'(1), N'(2));
      exp_gnt(0, 1'b1, N'(1), -1);
      exp_done(0, inv1, L + 1);
      exp_gnt(1, 1'b1, N'(2), 1);
      exp_done(1, inv2, L + 1);
      req = 2'b11;
      run(2, 2, 1'b1);
      repeat (3) @(negedge clk);

      // Fairness: both held for four services -> 0,1,0,1
      set_x(N'(3), N'(4));
      exp_gnt(0, 1'b1, N'(3), -1);
      exp_done(0, inv3, L + 1);
      exp_gnt(1, 1'b1, N'(4), 1);
      exp_done(1, inv4, L + 1);
      exp_gnt(0, 1'b1, N'(3), 1);
      exp_done(0, inv3, L + 1);
      exp_gnt(1, 1'b1, N'(4), 1);
      exp_done(1, inv4, L + 1);
      req = 2'b11;
      run(4, 3, 1'b0);
      req = 2'b00;
      run(0, 1, 1'b0);
      repeat (3) @(negedge clk);

      // Zero bypass on requester 1
      set_x(N'(9), N'(0));
      exp_gnt(1, 1'b0, N'(0), -1);
      exp_done(1, N'(0), 0);
      req = 2'b10;
      run(1, 1, 1'b1);
      repeat (4) @(negedge clk);

      // Reset in the cycle where cnt == 8; no done may follow
      set_x(N'(7), N'(0));
      exp_gnt(0, 1'b1, N'(7), -1);
      req = 2'b01;
      run(1, 0, 1'b1);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_cleared("midreset");
      rst_n = 1'b1;
      repeat (L + 5) @(negedge clk);

      // After reset the pointer restarts, so requester 0 wins first again
      set_x(N'(3), N'(4));
      exp_gnt(0, 1'b1, N'(3), -1);
      exp_done(0, inv3, L + 1);
      exp_gnt(1, 1'b1, N'(4), 1);
      exp_done(1, inv4, L + 1);
      req = 2'b11;
      run(2, 2, 1'b1);
      repeat (4) @(negedge clk);

      chk("pending_gnt", 256'(gq.size()), 256'd0);
      chk("pending_done", 256'(dq.size()), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
